// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-back mux, same-cycle bypass and load scoreboard
// Ports: clk, rst (async active-high); write_enable/rd/WBSel/PC/ALU_out/dmem_out/imm pick and
// commit the write-back value; raddr/rdata are NRD packed combinational read ports; busy_set/
// busy_rd mark a pending load; hazard flags reads of pending registers; busy_cnt counts them.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [AW-1:0]     rd,
    input  logic [1:0]        WBSel,
    input  logic [XLEN-1:0]   PC,
    input  logic [XLEN-1:0]   ALU_out,
    input  logic [XLEN-1:0]   dmem_out,
    input  logic [XLEN-1:0]   imm,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic              busy_set,
    input  logic [AW-1:0]     busy_rd,
    output logic [NRD-1:0]    hazard,
    output logic [AW:0]       busy_cnt
);
    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     busy_cnt_q, busy_cnt_d;
    logic [XLEN-1:0] wb_val;
    logic            wr_en;

    assign wb_val = (WBSel == 2'b00) ? PC + XLEN'(4) :
                    (WBSel == 2'b01) ? ALU_out :
                    (WBSel == 2'b10) ? dmem_out : imm;
    // rst gates the commit so the bypass path cannot leak a value while reset is held
    assign wr_en = write_enable && (rd != '0) && !rst;

    // clear before set: a new load issued on the commit edge keeps the register pending
    always_comb begin
        busy_d = busy_q;
        if (wr_en) busy_d[rd] = 1'b0;
        if (busy_set && busy_rd != '0) busy_d[busy_rd] = 1'b1;
        busy_d[0] = 1'b0;
        busy_cnt_d = '0;
        for (int i = 0; i < NREG; i++) busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        assign a = raddr[k*AW +: AW];
        assign rdata[k*XLEN +: XLEN] = (a == '0) ? '0 : (wr_en && a == rd) ? wb_val : regs_q[a];
        assign hazard[k] = !rst && (a != '0) && busy_q[a] && !(wr_en && a == rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_en) regs_q[rd] <= wb_val;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp with three read ports
module tb_regfile_mp;
    localparam int XLEN = 32, NREG = 32, NRD = 3, AW = 5;

    logic clk = 0, rst = 1, write_enable = 0, busy_set = 0;
    logic [AW-1:0] rd = '0, busy_rd = '0;
    logic [1:0] WBSel = '0;
    logic [XLEN-1:0] PC = '0, ALU_out = '0, dmem_out = '0, imm = '0;
    logic [NRD*AW-1:0] raddr = '0;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0] hazard;
    logic [AW:0] busy_cnt;

    int checks = 0, errors = 0;
    logic [XLEN-1:0] mem [NREG];
    logic [XLEN-1:0] exp_q [$];
    logic [XLEN-1:0] e;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .write_enable(write_enable), .rd(rd), .WBSel(WBSel),
        .PC(PC), .ALU_out(ALU_out), .dmem_out(dmem_out), .imm(imm), .raddr(raddr),
        .rdata(rdata), .busy_set(busy_set), .busy_rd(busy_rd), .hazard(hazard),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [NRD*AW-1:0] pack(input logic [AW-1:0] a0, a1, a2);
        return {a2, a1, a0};
    endfunction

    function automatic logic [XLEN-1:0] wbv(input logic [1:0] s, input logic [XLEN-1:0] v);
        return (s == 2'b00) ? v + 32'd4 : v;
    endfunction

    task automatic drive_src(input logic [1:0] s, input logic [XLEN-1:0] v);
        WBSel = s;
        PC = (s == 2'b00) ? v : 32'h0BAD_0000;
        ALU_out = (s == 2'b01) ? v : 32'h0BAD_0001;
        dmem_out = (s == 2'b10) ? v : 32'h0BAD_0002;
        imm = (s == 2'b11) ? v : 32'h0BAD_0003;
    endtask

    task automatic do_write(input logic [1:0] s, input logic [AW-1:0] r, input logic [XLEN-1:0] v);
        @(negedge clk);
        write_enable = 1; rd = r; drive_src(s, v);
        @(posedge clk); #1;
        write_enable = 0;
        if (r != 0) mem[r] = wbv(s, v);
    endtask

    task automatic test_reset();
        #3;
        raddr = pack(1, 2, 31);
        for (int k = 0; k < NRD; k++) exp_q.push_back('0);
        #1;
        for (int k = 0; k < NRD; k++) begin
            e = exp_q.pop_front(); checks++;
            if (rdata[k*XLEN +: XLEN] !== e) begin
                errors++; $display("FAIL reset_rdata%0d: got %h want %h", k, rdata[k*XLEN +: XLEN], e);
            end
        end
        checks++;
        if (hazard !== 3'b000 || busy_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_status: hazard %b cnt %0d want 000 0", hazard, busy_cnt);
        end
        @(negedge clk); rst = 0;
        for (int i = 0; i < NREG; i++) mem[i] = '0;
    endtask

    task automatic test_writeback();
        do_write(2'b01, 5, 32'd10);
        do_write(2'b10, 4, 32'd13);
        do_write(2'b00, 3, 32'd5);
        raddr = pack(5, 4, 3);
        exp_q.push_back(32'd10); exp_q.push_back(32'd13); exp_q.push_back(32'd9);
        #1;
        for (int k = 0; k < NRD; k++) begin
            e = exp_q.pop_front(); checks++;
            if (rdata[k*XLEN +: XLEN] !== e) begin
                errors++; $display("FAIL writeback_port%0d: got %h want %h", k, rdata[k*XLEN +: XLEN], e);
            end
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        write_enable = 1; rd = 0; drive_src(2'b01, 32'd10); raddr = pack(0, 0, 0);
        for (int k = 0; k < 2 * NRD; k++) exp_q.push_back('0);
        #1;
        for (int k = 0; k < NRD; k++) begin
            e = exp_q.pop_front(); checks++;
            if (rdata[k*XLEN +: XLEN] !== e) begin
                errors++; $display("FAIL x0_before_port%0d: got %h want %h", k, rdata[k*XLEN +: XLEN], e);
            end
        end
        @(posedge clk); #1; write_enable = 0; #1;
        for (int k = 0; k < NRD; k++) begin
            e = exp_q.pop_front(); checks++;
            if (rdata[k*XLEN +: XLEN] !== e) begin
                errors++; $display("FAIL x0_after_port%0d: got %h want %h", k, rdata[k*XLEN +: XLEN], e);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        write_enable = 1; rd = 7; drive_src(2'b11, 32'hDEADBEEF); raddr = pack(7, 5, 7);
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(mem[5]); exp_q.push_back(32'hDEADBEEF);
        #1;
        for (int k = 0; k < NRD; k++) begin
            e = exp_q.pop_front(); checks++;
            if (rdata[k*XLEN +: XLEN] !== e) begin
                errors++; $display("FAIL bypass_port%0d: got %h want %h", k, rdata[k*XLEN +: XLEN], e);
            end
        end
        @(posedge clk); #1; write_enable = 0; mem[7] = 32'hDEADBEEF;
        drive_src(2'b11, 32'h0); #1;
        exp_q.push_back(mem[7]);
        e = exp_q.pop_front(); checks++;
        if (rdata[XLEN-1:0] !== e) begin
            errors++; $display("FAIL bypass_stored: got %h want %h", rdata[XLEN-1:0], e);
        end
    endtask

    task automatic test_busy();
        @(negedge clk); busy_set = 1; busy_rd = 6;
        @(posedge clk); #1; busy_set = 0; raddr = pack(6, 6, 1); #1;
        checks++;
        if (hazard !== 3'b011 || busy_cnt !== 6'd1) begin
            errors++; $display("FAIL busy_pending: hazard %b cnt %0d want 011 1", hazard, busy_cnt);
        end
        @(negedge clk);
        write_enable = 1; rd = 6; drive_src(2'b10, 32'h55);
        exp_q.push_back(32'h55);
        #1;
        e = exp_q.pop_front(); checks++;
        if (hazard !== 3'b000 || rdata[XLEN-1:0] !== e || busy_cnt !== 6'd1) begin
            errors++; $display("FAIL busy_write_cycle: hazard %b data %h cnt %0d want 000 %h 1", hazard, rdata[XLEN-1:0], busy_cnt, e);
        end
        @(posedge clk); #1; write_enable = 0; mem[6] = 32'h55;
        exp_q.push_back(32'h55); #1;
        e = exp_q.pop_front(); checks++;
        if (hazard !== 3'b000 || rdata[XLEN +: XLEN] !== e || busy_cnt !== 6'd0) begin
            errors++; $display("FAIL busy_cleared: hazard %b data %h cnt %0d want 000 %h 0", hazard, rdata[XLEN +: XLEN], busy_cnt, e);
        end
    endtask

    task automatic test_same_edge();
        @(negedge clk);
        busy_set = 1; busy_rd = 8; write_enable = 1; rd = 8; drive_src(2'b01, 32'd3);
        @(posedge clk); #1; busy_set = 0; write_enable = 0; mem[8] = 32'd3;
        raddr = pack(8, 3, 8);
        exp_q.push_back(32'd3); #1;
        e = exp_q.pop_front(); checks++;
        if (rdata[XLEN-1:0] !== e || hazard !== 3'b101 || busy_cnt !== 6'd1) begin
            errors++; $display("FAIL same_edge: data %h hazard %b cnt %0d want %h 101 1", rdata[XLEN-1:0], hazard, busy_cnt, e);
        end
        do_write(2'b01, 8, 32'd4);
        checks++;
        if (busy_cnt !== 6'd0) begin
            errors++; $display("FAIL same_edge_release: cnt %0d want 0", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] s;
        logic [XLEN-1:0] v;
        @(negedge clk);
        for (int i = 10; i < 18; i++) begin
            s = 2'($urandom_range(0, 3)); v = $urandom;
            if (i == 10) begin s = 2'b00; v = 32'hFFFF_FFFE; end
            write_enable = 1; rd = AW'(i); drive_src(s, v);
            busy_set = 1; busy_rd = AW'(i + 10);
            mem[i] = wbv(s, v);
            @(negedge clk);
        end
        write_enable = 0; busy_set = 0;
        checks++;
        if (busy_cnt !== 6'd8) begin
            errors++; $display("FAIL b2b_busy_cnt: got %0d want 8", busy_cnt);
        end
        for (int i = 10; i < 18; i++) begin
            raddr = pack(AW'(i), AW'(i), AW'(i + 10));
            exp_q.push_back(mem[i]); exp_q.push_back(mem[i]);
            #1;
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front(); checks++;
                if (rdata[k*XLEN +: XLEN] !== e) begin
                    errors++; $display("FAIL b2b_x%0d_port%0d: got %h want %h", i, k, rdata[k*XLEN +: XLEN], e);
                end
            end
            checks++;
            if (hazard !== 3'b100) begin
                errors++; $display("FAIL b2b_hazard_x%0d: got %b want 100", i + 10, hazard);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 4; i++) do_write(2'b01, AW'(i), 32'h100 + i);
        @(negedge clk); busy_set = 1; busy_rd = 2;
        @(posedge clk); #1; busy_set = 0;
        @(negedge clk);
        write_enable = 1; rd = 5; drive_src(2'b01, 32'h77);
        busy_set = 1; busy_rd = 9; raddr = pack(1, 2, 5);
        #2; rst = 1;
        for (int i = 0; i < NREG; i++) mem[i] = '0;
        for (int k = 0; k < NRD; k++) exp_q.push_back('0);
        #1;
        for (int k = 0; k < NRD; k++) begin
            e = exp_q.pop_front(); checks++;
            if (rdata[k*XLEN +: XLEN] !== e) begin
                errors++; $display("FAIL async_rst_port%0d: got %h want %h", k, rdata[k*XLEN +: XLEN], e);
            end
        end
        checks++;
        if (hazard !== 3'b000 || busy_cnt !== 6'd0) begin
            errors++; $display("FAIL async_rst_status: hazard %b cnt %0d want 000 0", hazard, busy_cnt);
        end
        @(posedge clk); #1;
        raddr = pack(5, 9, 4);
        exp_q.push_back('0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rdata[XLEN-1:0] !== e || busy_cnt !== 6'd0 || hazard !== 3'b000) begin
            errors++; $display("FAIL rst_held_edge: data %h cnt %0d hazard %b want %h 0 000", rdata[XLEN-1:0], busy_cnt, hazard, e);
        end
        @(negedge clk); rst = 0; busy_set = 0; write_enable = 0;
        do_write(2'b11, 4, 32'hCAFE);
        raddr = pack(4, 1, 2);
        exp_q.push_back(32'hCAFE); exp_q.push_back('0); exp_q.push_back('0);
        #1;
        for (int k = 0; k < NRD; k++) begin
            e = exp_q.pop_front(); checks++;
            if (rdata[k*XLEN +: XLEN] !== e) begin
                errors++; $display("FAIL post_rst_write_port%0d: got %h want %h", k, rdata[k*XLEN +: XLEN], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_x0();
        test_bypass();
        test_busy();
        test_same_edge();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
